ct_ebiu_cawt_ctrl: RTL and testbench
====================================

Name: ct_ebiu_cawt_ctrl

Overview:
Control stage for the CA write table (CAWT).
- Accepts non-cacheable write addresses from the victim buffer (VB).
- Allocates a free CAWT entry and drives its per-entry create and pop strobes.
- Issues the AW beat to the bus through a one-deep holding register, with the entry index as AWID.
- Releases entries on B responses and aggregates per-entry address hits into write back-pressure and a read stall.
- Sits between the VB/EBIU interface and the array of CAWT entry instances.

Parameters:
ENTRY, 8, number of CAWT entries
IDX_W, 3, entry index / AWID width, equal to log2(ENTRY)
ADDRW, 40, physical address width

Ports:
forever_cpuclk  in  1  single clock, no other clock used
cpurst  in  1  synchronous, active-high reset
vb_ebiu_awvalid  in  1  VB write-address request
vb_ebiu_awaddr  in  ADDRW  VB write address
vb_ebiu_mid  in  3  VB master id
ebiu_vb_awready  out  1  VB request accepted this cycle
ebiu_bus_awvalid  out  1  bus AW valid
ebiu_bus_awaddr  out  ADDRW  bus AW address
ebiu_bus_awid  out  IDX_W  bus AW id, equal to the allocated entry index
bus_ebiu_awready  in  1  bus AW ready
bus_ebiu_bvalid  in  1  bus B valid
bus_ebiu_bid  in  IDX_W  bus B id
ebiu_bus_bready  out  1  B ready
cawt_vld  in  ENTRY  per-entry valid, fed back from the entries
ca_wr_addr_hit_cawt  in  ENTRY  per-entry write index hit
ca_rd_addr_hit_cawt  in  ENTRY  per-entry read index hit
cawt_create_en  out  ENTRY  one-hot entry valid set
cawt_create_dp_en  out  ENTRY  one-hot entry datapath capture
cawt_pop_en  out  ENTRY  one-hot entry valid clear
cawt_cnt  out  IDX_W+1  number of occupied entries
cawt_full  out  1  cawt_cnt == ENTRY
cawt_empty  out  1  cawt_cnt == 0
ebiu_ar_stall  out  1  a read must wait for an earlier write to the same index
cawt_bid_err  out  1  sticky flag: B response received for an invalid entry

Behaviour:
Reset (cpurst high at a clock edge):
- cawt_cnt=0, cawt_empty=1, cawt_full=0.
- Holding register cleared: ebiu_bus_awvalid=0, awaddr=0, awid=0.
- ebiu_bus_bready=0 during the reset cycle, then 1 from the first cycle after reset onward.
- cawt_bid_err=0.
- Reset mid-operation drops the held AW and all counts. The entries are reset by the same reset.

Free select:
- free = ~cawt_vld.
- alloc_idx is the lowest-index set bit of free.
- An entry created this cycle shows in cawt_vld on the next cycle, so no double allocation is possible.

Accept rule:
- ebiu_vb_awready = ~cawt_full & ~(|ca_wr_addr_hit_cawt) & (~ebiu_bus_awvalid | bus_ebiu_awready).
- cawt_full is the registered value. A pop in the same cycle does not open a slot until the next cycle.
- On acceptance (vb_ebiu_awvalid & ebiu_vb_awready), in the same cycle: cawt_create_en and cawt_create_dp_en are one-hot at alloc_idx. Both are zero otherwise.
- On the next edge: holding register loads {awaddr, alloc_idx} and ebiu_bus_awvalid becomes 1.

AW holding register:
- States: IDLE, HOLD.
- IDLE -> HOLD on accept.
- HOLD -> IDLE on bus_ebiu_awready with no new accept.
- HOLD -> HOLD when ready and accept coincide. The register reloads back-to-back with no bubble.
- awaddr and awid are stable while awvalid=1 and ready=0.

Pop:
- When bus_ebiu_bvalid & ebiu_bus_bready & cawt_vld[bid]: cawt_pop_en[bid]=1 for that cycle, combinationally. cawt_pop_en is zero otherwise.
- When bvalid & bready & ~cawt_vld[bid]: no pop, and cawt_bid_err is set. It stays set until reset.

Counter:
- +1 on accept, -1 on valid pop, unchanged when both or neither occur.
- Never exceeds ENTRY and never underflows.
- A pop and a create never target the same entry, because only free entries are allocated.

Read stall:
- ebiu_ar_stall = |ca_rd_addr_hit_cawt, combinational, zero latency.

Latency:
- VB accept to bus awvalid: 1 cycle.
- B response to entry free (cawt_vld low): 1 cycle.
- B response to reusable slot, as seen by the accept logic: 1 cycle.

Test Plan:
- Reset, then single write: awaddr=0x0000_1040, cawt_vld=0 -> awready=1, create_en=0x01; next cycle bus awvalid=1, awid=0, awaddr=0x0000_1040, cnt=1. Then bvalid, bid=0 -> pop_en=0x01, cnt=0.
- Fill: 8 back-to-back accepts with bus_awready=1 -> awids 0..7 in order, cnt=8, full=1. A 9th request sees awready=0. Then bid=3 -> pop_en=0x08; one cycle later awready=1 and the new entry gets awid=3.
- Write conflict: ca_wr_addr_hit_cawt=0x04 with awvalid=1 -> awready=0, create_en=0, cnt unchanged; hit clears -> accept the next cycle.
- Bus back-pressure: bus_awready=0 for 5 cycles after an accept -> awvalid, awaddr and awid held constant, VB awready=0. Ready=1 with a new request in the same cycle -> back-to-back reload, no bubble.
- Simultaneous accept and pop with cnt=4 -> cnt stays 4, create_en and pop_en target different entries. Then bvalid with bid=6 while cawt_vld[6]=0 -> no pop, cawt_bid_err=1 and it stays set until cpurst.
- Reset mid-operation: assert cpurst while awvalid=1 and cnt=5 -> next cycle awvalid=0, cnt=0, empty=1, bid_err=0.

Source files
------------

// File: rtl/ct_ebiu_cawt_ctrl.sv
// ct_ebiu_cawt_ctrl
// Control stage for the CA write table (CAWT). It takes non-cacheable write
// addresses from the victim buffer and places each one in the lowest free
// entry. The address goes out to the bus through a one-deep AW holding
// register, with the entry index used as AWID. A B response releases the
// entry whose index matches BID. Per-entry address hits produce write
// back-pressure and the read stall.
//
// Ports
//   forever_cpuclk, cpurst          clock, synchronous active-high reset
//   vb_ebiu_aw*, ebiu_vb_awready    VB write-address request / accept
//   ebiu_bus_aw*, bus_ebiu_awready  bus AW channel
//   bus_ebiu_b*, ebiu_bus_bready    bus B channel
//   cawt_vld, ca_*_addr_hit_cawt    per-entry feedback from the entry array
//   cawt_create_en/_dp_en/pop_en    one-hot per-entry strobes
//   cawt_cnt/full/empty             occupancy
//   ebiu_ar_stall, cawt_bid_err     read stall, sticky bad-BID flag
//
// AW holding register states
//   state   | meaning
//   AW_IDLE | holding register empty, ebiu_bus_awvalid low
//   AW_HOLD | address/id held for the bus, ebiu_bus_awvalid high

module ct_ebiu_cawt_ctrl #(
   parameter int ENTRY = 8,
   parameter int IDX_W = 3,
   parameter int ADDRW = 40
) (
   input  logic               forever_cpuclk,
   input  logic               cpurst,
   input  logic               vb_ebiu_awvalid,
   input  logic [ADDRW-1:0]   vb_ebiu_awaddr,
   input  logic [2:0]         vb_ebiu_mid,
   output logic               ebiu_vb_awready,
   output logic               ebiu_bus_awvalid,
   output logic [ADDRW-1:0]   ebiu_bus_awaddr,
   output logic [IDX_W-1:0]   ebiu_bus_awid,
   input  logic               bus_ebiu_awready,
   input  logic               bus_ebiu_bvalid,
   input  logic [IDX_W-1:0]   bus_ebiu_bid,
   output logic               ebiu_bus_bready,
   input  logic [ENTRY-1:0]   cawt_vld,
   input  logic [ENTRY-1:0]   ca_wr_addr_hit_cawt,
   input  logic [ENTRY-1:0]   ca_rd_addr_hit_cawt,
   output logic [ENTRY-1:0]   cawt_create_en,
   output logic [ENTRY-1:0]   cawt_create_dp_en,
   output logic [ENTRY-1:0]   cawt_pop_en,
   output logic [IDX_W:0]     cawt_cnt,
   output logic               cawt_full,
   output logic               cawt_empty,
   output logic               ebiu_ar_stall,
   output logic               cawt_bid_err
);

   typedef enum logic {AW_IDLE, AW_HOLD} aw_state_t;

   localparam logic [IDX_W:0]   CNT_MAX = (IDX_W+1)'(ENTRY);
   localparam logic [ENTRY-1:0] ONE_HOT = {{(ENTRY-1){1'b0}}, 1'b1};

   aw_state_t         aw_state;
   logic [ENTRY-1:0]  free;
   logic [IDX_W-1:0]  alloc_idx;
   logic              alloc_found;
   logic              vb_accept;
   logic              b_hs;
   logic              pop_vld;
   logic              bid_bad;
   logic              bready_q;
   logic [IDX_W:0]    cnt_q;
   logic              bid_err_q;

   // The master id carries no information for allocation or ordering.
   logic unused_mid;
   assign unused_mid = ^vb_ebiu_mid;

   assign free = ~cawt_vld;

   // Lowest-index free entry. A freshly created entry shows up in cawt_vld
   // on the next cycle, so it cannot be picked twice.
   always_comb begin
      alloc_idx   = '0;
      alloc_found = 1'b0;
      for (int i = 0; i < ENTRY; i++) begin
         if (free[i] && !alloc_found) begin
            alloc_idx   = IDX_W'(i);
            alloc_found = 1'b1;
         end
      end
   end

   // cawt_full is taken from the registered count, so a pop in this cycle
   // only opens a slot from the next cycle on.
   assign ebiu_vb_awready = ~cawt_full & ~(|ca_wr_addr_hit_cawt)
                          & (~ebiu_bus_awvalid | bus_ebiu_awready);
   assign vb_accept       = vb_ebiu_awvalid & ebiu_vb_awready;

   assign cawt_create_en    = vb_accept ? (ONE_HOT << alloc_idx) : '0;
   assign cawt_create_dp_en = cawt_create_en;

   assign b_hs    = bus_ebiu_bvalid & ebiu_bus_bready;
   assign pop_vld = b_hs &  cawt_vld[bus_ebiu_bid];
   assign bid_bad = b_hs & ~cawt_vld[bus_ebiu_bid];

   assign cawt_pop_en = pop_vld ? (ONE_HOT << bus_ebiu_bid) : '0;

   assign ebiu_ar_stall = |ca_rd_addr_hit_cawt;

   // AW holding register. A ready and a new accept in the same cycle reload
   // the register directly, so there is no bubble between bursts.
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         aw_state         <= AW_IDLE;
         ebiu_bus_awvalid <= 1'b0;
         ebiu_bus_awaddr  <= '0;
         ebiu_bus_awid    <= '0;
      end else begin
         case (aw_state)
            AW_IDLE: begin
               if (vb_accept) begin
                  aw_state         <= AW_HOLD;
                  ebiu_bus_awvalid <= 1'b1;
                  ebiu_bus_awaddr  <= vb_ebiu_awaddr;
                  ebiu_bus_awid    <= alloc_idx;
               end
            end
            AW_HOLD: begin
               if (vb_accept) begin
                  ebiu_bus_awaddr  <= vb_ebiu_awaddr;
                  ebiu_bus_awid    <= alloc_idx;
               end else if (bus_ebiu_awready) begin
                  aw_state         <= AW_IDLE;
                  ebiu_bus_awvalid <= 1'b0;
               end
            end
            default: begin
               aw_state         <= AW_IDLE;
               ebiu_bus_awvalid <= 1'b0;
            end
         endcase
      end
   end

   // Occupancy count; the guards keep it within 0..ENTRY even if the entry
   // feedback and the count ever disagree.
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         cnt_q <= '0;
      end else begin
         case ({vb_accept, pop_vld})
            2'b10:   if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
            2'b01:   if (cnt_q != '0)      cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // B ready stays low through the reset cycle, then stays high.
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         bready_q  <= 1'b0;
         bid_err_q <= 1'b0;
      end else begin
         bready_q  <= 1'b1;
         if (bid_bad) bid_err_q <= 1'b1;
      end
   end

   assign ebiu_bus_bready = bready_q;
   assign cawt_bid_err    = bid_err_q;
   assign cawt_cnt        = cnt_q;
   assign cawt_full       = (cnt_q == CNT_MAX);
   assign cawt_empty      = (cnt_q == '0);

endmodule

// File: tb/tb_ct_ebiu_cawt_ctrl.sv
module tb_ct_ebiu_cawt_ctrl;

   logic        clk = 1'b0;
   logic        cpurst;
   logic        vb_awvalid;
   logic [39:0] vb_awaddr;
   logic [2:0]  vb_mid;
   logic        vb_awready;
   logic        bus_awvalid;
   logic [39:0] bus_awaddr;
   logic [2:0]  bus_awid;
   logic        bus_awready;
   logic        bus_bvalid;
   logic [2:0]  bus_bid;
   logic        bus_bready;
   logic [7:0]  tb_vld;
   logic [7:0]  wr_hit;
   logic [7:0]  rd_hit;
   logic [7:0]  create_en;
   logic [7:0]  create_dp_en;
   logic [7:0]  pop_en;
   logic [3:0]  cnt;
   logic        full;
   logic        empty;
   logic        ar_stall;
   logic        bid_err;

   always #5 clk = ~clk;

   ct_ebiu_cawt_ctrl dut (
      .forever_cpuclk      (clk),
      .cpurst              (cpurst),
      .vb_ebiu_awvalid     (vb_awvalid),
      .vb_ebiu_awaddr      (vb_awaddr),
      .vb_ebiu_mid         (vb_mid),
      .ebiu_vb_awready     (vb_awready),
      .ebiu_bus_awvalid    (bus_awvalid),
      .ebiu_bus_awaddr     (bus_awaddr),
      .ebiu_bus_awid       (bus_awid),
      .bus_ebiu_awready    (bus_awready),
      .bus_ebiu_bvalid     (bus_bvalid),
      .bus_ebiu_bid        (bus_bid),
      .ebiu_bus_bready     (bus_bready),
      .cawt_vld            (tb_vld),
      .ca_wr_addr_hit_cawt (wr_hit),
      .ca_rd_addr_hit_cawt (rd_hit),
      .cawt_create_en      (create_en),
      .cawt_create_dp_en   (create_dp_en),
      .cawt_pop_en         (pop_en),
      .cawt_cnt            (cnt),
      .cawt_full           (full),
      .cawt_empty          (empty),
      .ebiu_ar_stall       (ar_stall),
      .cawt_bid_err        (bid_err)
   );

   // Stand-in for the CAWT entry array: entries latch create/pop strobes.
   always @(posedge clk) begin
      if (cpurst) tb_vld <= 8'h00;
      else        tb_vld <= (tb_vld | create_en) & ~pop_en;
   end

   int n_checks = 0;
   int n_errors = 0;

   // Reference model of the controller's visible state.
   int          m_cnt;
   bit          m_hv;
   logic [39:0] m_ha;
   logic [2:0]  m_hid;
   bit          m_bready;
   bit          m_err;

   // Expectations for the current cycle.
   bit          e_ready;
   int          e_idx;
   logic [7:0]  e_create;
   logic [7:0]  e_pop;
   bit          e_stall;

   task automatic model_reset();
      m_cnt = 0; m_hv = 0; m_ha = '0; m_hid = '0; m_bready = 0; m_err = 0;
   endtask

   task automatic apply(input bit awv, input logic [39:0] a, input bit brdy,
                        input bit bv, input int bid,
                        input logic [7:0] wh, input logic [7:0] rh);
      vb_awvalid  = awv;
      vb_awaddr   = a;
      vb_mid      = 3'($urandom);
      bus_awready = brdy;
      bus_bvalid  = bv;
      bus_bid     = 3'(bid);
      wr_hit      = wh;
      rd_hit      = rh;
      #1;
      e_idx = -1;
      for (int i = 0; i < 8; i++)
         if (tb_vld[i] !== 1'b1 && e_idx < 0) e_idx = i;
      e_ready  = (m_cnt != 8) && (wh == 8'h00) && (!m_hv || brdy);
      e_create = (awv && e_ready && e_idx >= 0) ? 8'(1 << e_idx) : 8'h00;
      e_pop    = (bv && m_bready && tb_vld[bid] === 1'b1) ? 8'(1 << bid) : 8'h00;
      e_stall  = (rh != 8'h00);
   endtask

   task automatic tick();
      bit          acc;
      bit          popv;
      bit          bad;
      bit          brdy;
      logic [39:0] a;
      int          idx;
      acc  = vb_awvalid && e_ready;
      popv = (e_pop != 8'h00);
      bad  = bus_bvalid && m_bready && (tb_vld[bus_bid] !== 1'b1);
      brdy = bus_awready;
      a    = vb_awaddr;
      idx  = e_idx;
      @(posedge clk);
      if (cpurst) begin
         model_reset();
      end else begin
         m_bready = 1;
         if (bad) m_err = 1;
         if (acc) begin
            m_hv = 1; m_ha = a; m_hid = 3'(idx);
         end else if (brdy) begin
            m_hv = 0;
         end
         m_cnt = m_cnt + int'(acc) - int'(popv);
      end
      #1;
   endtask

   task automatic idle(input bit brdy);
      apply(0, '0, brdy, 0, 0, 8'h00, 8'h00);
   endtask

   // Return every occupied entry through B responses and empty the AW register.
   task automatic drain();
      int guard;
      int bid;
      guard = 0;
      while ((tb_vld != 8'h00 || m_hv) && guard < 40) begin
         bid = 0;
         for (int i = 7; i >= 0; i--) if (tb_vld[i]) bid = i;
         apply(0, '0, 1, tb_vld != 8'h00, bid, 8'h00, 8'h00);
         tick();
         guard++;
      end
      n_checks++;
      if (tb_vld != 8'h00 || m_hv || cnt !== 4'd0) begin
         n_errors++;
         $display("FAIL drain_timeout vld=%h cnt=%0d exp vld=00 cnt=0", tb_vld, cnt);
      end
   endtask

   task automatic test_reset();
      cpurst = 1;
      idle(0);
      tick();
      tick();
      n_checks++; if (cnt !== 4'd0) begin n_errors++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
      n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty got %b exp 1", empty); end
      n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full got %b exp 0", full); end
      n_checks++; if (bus_awvalid !== 1'b0 || bus_awaddr !== 40'h0 || bus_awid !== 3'd0) begin
         n_errors++; $display("FAIL reset_aw got v=%b a=%h id=%0d exp 0/0/0", bus_awvalid, bus_awaddr, bus_awid); end
      n_checks++; if (bus_bready !== 1'b0) begin n_errors++; $display("FAIL reset_bready got %b exp 0", bus_bready); end
      n_checks++; if (bid_err !== 1'b0) begin n_errors++; $display("FAIL reset_biderr got %b exp 0", bid_err); end
      cpurst = 0;
      idle(0);
      tick();
      n_checks++; if (bus_bready !== 1'b1) begin n_errors++; $display("FAIL post_reset_bready got %b exp 1", bus_bready); end
   endtask

   task automatic test_single();
      apply(1, 40'h0000_1040, 1, 0, 0, 8'h00, 8'h00);
      n_checks++; if (vb_awready !== 1'b1) begin n_errors++; $display("FAIL single_ready got %b exp 1", vb_awready); end
      n_checks++; if (create_en !== 8'h01 || create_dp_en !== 8'h01) begin
         n_errors++; $display("FAIL single_create got %h/%h exp 01", create_en, create_dp_en); end
      tick();
      idle(0);
      n_checks++; if (bus_awvalid !== 1'b1 || bus_awid !== 3'd0 || bus_awaddr !== 40'h0000_1040) begin
         n_errors++; $display("FAIL single_aw got v=%b id=%0d a=%h exp 1/0/1040", bus_awvalid, bus_awid, bus_awaddr); end
      n_checks++; if (cnt !== 4'd1) begin n_errors++; $display("FAIL single_cnt got %0d exp 1", cnt); end
      tick();
      apply(0, '0, 1, 1, 0, 8'h00, 8'h00);
      n_checks++; if (pop_en !== 8'h01) begin n_errors++; $display("FAIL single_pop got %h exp 01", pop_en); end
      tick();
      n_checks++; if (cnt !== 4'd0 || tb_vld !== 8'h00) begin
         n_errors++; $display("FAIL single_free got cnt=%0d vld=%h exp 0/00", cnt, tb_vld); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 8; i++) begin
         apply(1, 40'(64'h2000 + i * 64), 1, 0, 0, 8'h00, 8'h00);
         n_checks++; if (create_en !== 8'(1 << i)) begin
            n_errors++; $display("FAIL fill_create got %h exp %h", create_en, 8'(1 << i)); end
         tick();
         n_checks++; if (bus_awvalid !== 1'b1 || bus_awid !== 3'(i)) begin
            n_errors++; $display("FAIL fill_awid got v=%b id=%0d exp 1/%0d", bus_awvalid, bus_awid, i); end
      end
      n_checks++; if (cnt !== 4'd8 || full !== 1'b1) begin
         n_errors++; $display("FAIL fill_full got cnt=%0d full=%b exp 8/1", cnt, full); end
      apply(1, 40'h9999, 1, 0, 0, 8'h00, 8'h00);
      n_checks++; if (vb_awready !== 1'b0 || create_en !== 8'h00) begin
         n_errors++; $display("FAIL fill_ninth got rdy=%b cr=%h exp 0/00", vb_awready, create_en); end
      tick();
      apply(1, 40'h9999, 1, 1, 3, 8'h00, 8'h00);
      n_checks++; if (vb_awready !== 1'b0 || pop_en !== 8'h08) begin
         n_errors++; $display("FAIL fill_pop got rdy=%b pop=%h exp 0/08", vb_awready, pop_en); end
      tick();
      apply(1, 40'h0000_ABC0, 1, 0, 0, 8'h00, 8'h00);
      n_checks++; if (vb_awready !== 1'b1 || create_en !== 8'h08) begin
         n_errors++; $display("FAIL fill_reuse got rdy=%b cr=%h exp 1/08", vb_awready, create_en); end
      tick();
      n_checks++; if (bus_awid !== 3'd3 || bus_awaddr !== 40'h0000_ABC0) begin
         n_errors++; $display("FAIL fill_reuse_aw got id=%0d a=%h exp 3/abc0", bus_awid, bus_awaddr); end
      drain();
   endtask

   task automatic test_conflict();
      apply(1, 40'h3000, 1, 0, 0, 8'h04, 8'h20);
      n_checks++; if (vb_awready !== 1'b0 || create_en !== 8'h00) begin
         n_errors++; $display("FAIL conflict_block got rdy=%b cr=%h exp 0/00", vb_awready, create_en); end
      n_checks++; if (ar_stall !== 1'b1) begin n_errors++; $display("FAIL conflict_stall got %b exp 1", ar_stall); end
      tick();
      n_checks++; if (cnt !== 4'd0 || bus_awvalid !== 1'b0) begin
         n_errors++; $display("FAIL conflict_cnt got cnt=%0d v=%b exp 0/0", cnt, bus_awvalid); end
      apply(1, 40'h3000, 1, 0, 0, 8'h00, 8'h00);
      n_checks++; if (vb_awready !== 1'b1 || create_en !== 8'h01 || ar_stall !== 1'b0) begin
         n_errors++; $display("FAIL conflict_release got rdy=%b cr=%h st=%b exp 1/01/0", vb_awready, create_en, ar_stall); end
      tick();
      drain();
   endtask

   task automatic test_backpressure();
      apply(1, 40'h00_DEAD_0000, 1, 0, 0, 8'h00, 8'h00);
      tick();
      for (int i = 0; i < 5; i++) begin
         apply(1, 40'h00_BEEF_0000, 0, 0, 0, 8'h00, 8'h00);
         n_checks++; if (bus_awvalid !== 1'b1 || bus_awaddr !== 40'h00_DEAD_0000 || bus_awid !== 3'd0) begin
            n_errors++; $display("FAIL bp_hold got v=%b a=%h id=%0d exp 1/dead0000/0", bus_awvalid, bus_awaddr, bus_awid); end
         n_checks++; if (vb_awready !== 1'b0) begin n_errors++; $display("FAIL bp_ready got %b exp 0", vb_awready); end
         tick();
      end
      apply(1, 40'h00_BEEF_0000, 1, 0, 0, 8'h00, 8'h00);
      n_checks++; if (vb_awready !== 1'b1) begin n_errors++; $display("FAIL bp_release got %b exp 1", vb_awready); end
      tick();
      n_checks++; if (bus_awvalid !== 1'b1 || bus_awaddr !== 40'h00_BEEF_0000 || bus_awid !== 3'd1) begin
         n_errors++; $display("FAIL bp_b2b got v=%b a=%h id=%0d exp 1/beef0000/1", bus_awvalid, bus_awaddr, bus_awid); end
      drain();
   endtask

   task automatic test_simul();
      for (int i = 0; i < 4; i++) begin
         apply(1, 40'(64'h4000 + i), 1, 0, 0, 8'h00, 8'h00);
         tick();
      end
      apply(1, 40'h5000, 1, 1, 1, 8'h00, 8'h00);
      n_checks++; if (create_en !== 8'h10 || pop_en !== 8'h02) begin
         n_errors++; $display("FAIL simul_strobes got cr=%h pop=%h exp 10/02", create_en, pop_en); end
      tick();
      n_checks++; if (cnt !== 4'd4) begin n_errors++; $display("FAIL simul_cnt got %0d exp 4", cnt); end
      apply(0, '0, 1, 1, 6, 8'h00, 8'h00);
      n_checks++; if (pop_en !== 8'h00) begin n_errors++; $display("FAIL badbid_pop got %h exp 00", pop_en); end
      tick();
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (bid_err !== 1'b1 || cnt !== 4'd4) begin
            n_errors++; $display("FAIL badbid_sticky got err=%b cnt=%0d exp 1/4", bid_err, cnt); end
         idle(1);
         tick();
      end
      drain();
      n_checks++; if (bid_err !== 1'b1) begin n_errors++; $display("FAIL badbid_after_drain got %b exp 1", bid_err); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         apply(1, 40'(64'h6000 + i * 16), 1, 0, 0, 8'h00, 8'h00);
         tick();
      end
      n_checks++; if (cnt !== 4'd5 || bus_awvalid !== 1'b1) begin
         n_errors++; $display("FAIL rstmid_pre got cnt=%0d v=%b exp 5/1", cnt, bus_awvalid); end
      cpurst = 1;
      idle(0);
      tick();
      n_checks++; if (bus_awvalid !== 1'b0 || cnt !== 4'd0 || empty !== 1'b1 || bid_err !== 1'b0) begin
         n_errors++; $display("FAIL rstmid_post got v=%b cnt=%0d empty=%b err=%b exp 0/0/1/0", bus_awvalid, cnt, empty, bid_err); end
      cpurst = 0;
      idle(0);
      tick();
   endtask

   task automatic test_random();
      bit          awv;
      bit          brdy;
      bit          bv;
      int          bid;
      logic [7:0]  wh;
      logic [7:0]  rh;
      logic [39:0] a;
      int          pick;
      for (int c = 0; c < 400; c++) begin
         awv  = ($urandom_range(0, 2) != 0);
         brdy = ($urandom_range(0, 3) != 0);
         bv   = ($urandom_range(0, 2) == 0);
         bid  = $urandom_range(0, 7);
         if (tb_vld != 8'h00 && $urandom_range(0, 15) != 0) begin
            pick = $urandom_range(0, 7);
            while (!tb_vld[pick]) pick = (pick + 1) % 8;
            bid = pick;
         end
         wh = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         rh = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
         a  = {8'($urandom), 32'($urandom)};
         apply(awv, a, brdy, bv, bid, wh, rh);
         n_checks++; if (vb_awready !== e_ready) begin
            n_errors++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, vb_awready, e_ready); end
         n_checks++; if (create_en !== e_create || create_dp_en !== e_create) begin
            n_errors++; $display("FAIL rnd_create c=%0d got %h/%h exp %h", c, create_en, create_dp_en, e_create); end
         n_checks++; if (pop_en !== e_pop) begin
            n_errors++; $display("FAIL rnd_pop c=%0d got %h exp %h", c, pop_en, e_pop); end
         n_checks++; if (ar_stall !== e_stall) begin
            n_errors++; $display("FAIL rnd_stall c=%0d got %b exp %b", c, ar_stall, e_stall); end
         n_checks++; if (bus_awvalid !== m_hv || (m_hv && (bus_awaddr !== m_ha || bus_awid !== m_hid))) begin
            n_errors++; $display("FAIL rnd_aw c=%0d got v=%b a=%h id=%0d exp v=%b a=%h id=%0d", c, bus_awvalid, bus_awaddr, bus_awid, m_hv, m_ha, m_hid); end
         n_checks++; if (cnt !== 4'(m_cnt) || full !== (m_cnt == 8) || empty !== (m_cnt == 0)) begin
            n_errors++; $display("FAIL rnd_cnt c=%0d got %0d f=%b e=%b exp %0d", c, cnt, full, empty, m_cnt); end
         n_checks++; if (bus_bready !== m_bready || bid_err !== m_err) begin
            n_errors++; $display("FAIL rnd_b c=%0d got rdy=%b err=%b exp %b/%b", c, bus_bready, bid_err, m_bready, m_err); end
         tick();
      end
   endtask

   initial begin
      model_reset();
      cpurst      = 1;
      vb_awvalid  = 0;
      vb_awaddr   = '0;
      vb_mid      = '0;
      bus_awready = 0;
      bus_bvalid  = 0;
      bus_bid     = '0;
      wr_hit      = '0;
      rd_hit      = '0;
      #1;
      test_reset();
      test_single();
      test_fill();
      test_conflict();
      test_backpressure();
      test_simul();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
